// File: rtl/generic_bus_write_buffer_if.sv
// Generic single-transaction bus: request side (master) drives address, data and strobes;
// the responder (slave) answers with read data and a busy/complete flag.
interface generic_bus_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] byte_en;
  logic                ren;
  logic                wen;
  logic [DATA_W-1:0]   rdata;
  logic                busy;

  modport master (output addr, wdata, byte_en, ren, wen, input rdata, busy);
  modport slave  (input addr, wdata, byte_en, ren, wen, output rdata, busy);
endinterface

// File: rtl/generic_bus_write_buffer.sv
// Posted-write FIFO between the CPU bus and the memory-side translator; reads wait for the FIFO to drain.
// Optional store-to-load forwarding of full-word writes is enabled with `define WB_READ_FORWARD_EN.
module generic_bus_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  generic_bus_write_buffer_if.slave     cpu,
  generic_bus_write_buffer_if.master    mem,
  output logic                          wb_empty
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;

  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [BE_W-1:0]    be_mem   [DEPTH];

  logic               rd_req, push, pop;
  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;

  // A simultaneous read+write request is treated as a write only.
  assign rd_req = cpu.ren & ~cpu.wen;
  assign pop    = (state_reg == DRAIN) & ~mem.busy;
  // nRST gates acceptance so cpu_busy reads 1 while reset is held.
  assign push   = nRST & cpu.wen & (state_reg != READ) &
                  ((count_reg < CNT_W'(DEPTH)) | pop);
  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign wb_empty   = (count_reg == '0) & (state_reg != DRAIN);

`ifdef WB_READ_FORWARD_EN
  logic [DEPTH-1:0] entry_match;
  logic             fwd_found;
  logic [PTR_W-1:0] fwd_idx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic entry_valid;
    assign entry_valid     = {1'b0, PTR_W'(gi) - rd_ptr_reg} < count_reg;
    assign entry_match[gi] = entry_valid &
                             (addr_mem[gi][ADDR_W-1:2] == cpu.addr[ADDR_W-1:2]);
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_match[rd_ptr_reg + PTR_W'(k)]) begin
        fwd_found = 1'b1;
        fwd_idx   = rd_ptr_reg + PTR_W'(k);
      end
    end
  end

  assign fwd_hit  = rd_req & (state_reg == DRAIN) & fwd_found & (&be_mem[fwd_idx]);
  assign fwd_data = data_mem[fwd_idx];
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_next  = state_reg;
    cpu.busy    = 1'b1;
    cpu.rdata   = '0;
    mem.addr    = '0;
    mem.wdata   = '0;
    mem.byte_en = '0;
    mem.ren     = 1'b0;
    mem.wen     = 1'b0;
    if (push) cpu.busy = 1'b0;
    case (state_reg)
      IDLE: begin
        if (push)        state_next = DRAIN;
        else if (rd_req) state_next = READ;
      end
      DRAIN: begin
        mem.addr    = addr_mem[rd_ptr_reg];
        mem.wdata   = data_mem[rd_ptr_reg];
        mem.byte_en = be_mem[rd_ptr_reg];
        mem.wen     = 1'b1;
        if (fwd_hit) begin
          cpu.busy  = 1'b0;
          cpu.rdata = fwd_data;
        end
        if (count_next == '0) state_next = (rd_req & ~fwd_hit) ? READ : IDLE;
      end
      READ: begin
        mem.addr    = cpu.addr;
        mem.byte_en = cpu.byte_en;
        mem.ren     = 1'b1;
        cpu.rdata   = mem.rdata;
        cpu.busy    = mem.busy | cpu.wen;
        if (!mem.busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // When full, push and pop share a slot: the head is consumed this cycle, overwritten at the edge.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= cpu.addr;
      data_mem[wr_ptr_reg] <= cpu.wdata;
      be_mem[wr_ptr_reg]   <= cpu.byte_en;
    end
  end

`ifndef SYNTHESIS
  a_no_rw_together: assert property (@(posedge CLK) disable iff (!nRST) !(cpu.ren && cpu.wen));
`endif
endmodule

// File: tb/tb_generic_bus_write_buffer.sv
// Directed, cycle-by-cycle vector bench for generic_bus_write_buffer (DEPTH=4, 32-bit bus).
// Build with +define+WB_READ_FORWARD_EN to check the forwarding expectations.
module tb_generic_bus_write_buffer;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic wb_empty;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  generic_bus_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
  generic_bus_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  generic_bus_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(clk), .nRST(nrst), .cpu(cpu_if), .mem(mem_if), .wb_empty(wb_empty)
  );

  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
    logic ren; logic wen; logic mbusy; logic [31:0] mrdata;
    logic e_busy; logic e_wen; logic e_ren;
    logic [31:0] e_addr; logic [31:0] e_wdata; logic [3:0] e_be;
    logic [31:0] e_rdata; logic e_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     input logic ren, input logic wen, input logic mbusy, input logic [31:0] mrdata,
                     input logic e_busy, input logic e_wen, input logic e_ren,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_be,
                     input logic [31:0] e_rdata, input logic e_empty);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.be = be; v.ren = ren; v.wen = wen;
    v.mbusy = mbusy; v.mrdata = mrdata; v.e_busy = e_busy; v.e_wen = e_wen; v.e_ren = e_ren;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be; v.e_rdata = e_rdata; v.e_empty = e_empty;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                       input logic ren, input logic wen, input logic mbusy, input logic [31:0] mrdata);
    cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.byte_en = be;
    cpu_if.ren = ren; cpu_if.wen = wen; mem_if.busy = mbusy; mem_if.rdata = mrdata;
  endtask

  initial begin
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    // Scenario 1: four zero-wait writes draining back to back.
    add(32'h100, 32'h11, 4'hF, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    add(32'h104, 32'h22, 4'hF, 0, 1, 0, 0,  0, 1, 0, 32'h100, 32'h11, 4'hF, 0, 0);
    add(32'h108, 32'h33, 4'hF, 0, 1, 0, 0,  0, 1, 0, 32'h104, 32'h22, 4'hF, 0, 0);
    add(32'h10C, 32'h44, 4'hF, 0, 1, 0, 0,  0, 1, 0, 32'h108, 32'h33, 4'hF, 0, 0);
    add(32'h0,   32'h0,  4'h0, 0, 0, 0, 0,  1, 1, 0, 32'h10C, 32'h44, 4'hF, 0, 0);
    add(32'h0,   32'h0,  4'h0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1);
    // Scenario 2: fill with memory stalled, fifth write rides on a coincident pop.
    add(32'h600, 32'h1, 4'h1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    add(32'h604, 32'h2, 4'h3, 0, 1, 1, 0,  0, 1, 0, 32'h600, 32'h1, 4'h1, 0, 0);
    add(32'h608, 32'h3, 4'h7, 0, 1, 1, 0,  0, 1, 0, 32'h600, 32'h1, 4'h1, 0, 0);
    add(32'h60C, 32'h4, 4'hF, 0, 1, 1, 0,  0, 1, 0, 32'h600, 32'h1, 4'h1, 0, 0);
    add(32'h610, 32'h5, 4'h8, 0, 1, 1, 0,  1, 1, 0, 32'h600, 32'h1, 4'h1, 0, 0);
    add(32'h610, 32'h5, 4'h8, 0, 1, 0, 0,  0, 1, 0, 32'h600, 32'h1, 4'h1, 0, 0);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 1, 0, 32'h604, 32'h2, 4'h3, 0, 0);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 1, 0, 32'h608, 32'h3, 4'h7, 0, 0);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 1, 0, 32'h60C, 32'h4, 4'hF, 0, 0);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 1, 0, 32'h610, 32'h5, 4'h8, 0, 0);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1);
    // Scenario 3: read ordered behind a buffered write.
    add(32'h200, 32'hDEAD, 4'hF, 0, 1, 0, 0,         0, 0, 0, 0, 0, 0, 0, 1);
    add(32'h300, 32'h0,    4'hF, 1, 0, 0, 32'hCAFE,  1, 1, 0, 32'h200, 32'hDEAD, 4'hF, 0, 0);
    add(32'h300, 32'h0,    4'hF, 1, 0, 0, 32'hCAFE,  0, 0, 1, 32'h300, 0, 4'hF, 32'hCAFE, 1);
    add(32'h0,   32'h0,    4'h0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1);
    // Scenario 4: read on empty FIFO with a slow memory.
    add(32'h400, 32'h0, 4'hF, 1, 0, 1, 32'hBEEF,  1, 0, 0, 0, 0, 0, 0, 1);
    add(32'h400, 32'h0, 4'hF, 1, 0, 1, 32'hBEEF,  1, 0, 1, 32'h400, 0, 4'hF, 0, 1);
    add(32'h400, 32'h0, 4'hF, 1, 0, 1, 32'hBEEF,  1, 0, 1, 32'h400, 0, 4'hF, 0, 1);
    add(32'h400, 32'h0, 4'hF, 1, 0, 0, 32'hBEEF,  0, 0, 1, 32'h400, 0, 4'hF, 32'hBEEF, 1);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 1);
    // Scenario 6a: full-word write followed by a read of the same word.
    add(32'h500, 32'h12345678, 4'hF, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);
`ifdef WB_READ_FORWARD_EN
    add(32'h500, 32'h0, 4'hF, 1, 0, 1, 0,  0, 1, 0, 32'h500, 32'h12345678, 4'hF, 32'h12345678, 0);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 1, 0, 32'h500, 32'h12345678, 4'hF, 0, 0);
`else
    add(32'h500, 32'h0, 4'hF, 1, 0, 1, 0,      1, 1, 0, 32'h500, 32'h12345678, 4'hF, 0, 0);
    add(32'h500, 32'h0, 4'hF, 1, 0, 0, 0,      1, 1, 0, 32'h500, 32'h12345678, 4'hF, 0, 0);
    add(32'h500, 32'h0, 4'hF, 1, 0, 0, 32'h77, 0, 0, 1, 32'h500, 0, 4'hF, 32'h77, 1);
`endif
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1);
    // Scenario 6b: partial-byte write never forwards.
    add(32'h500, 32'hAABBCCDD, 4'h3, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    add(32'h500, 32'h0, 4'hF, 1, 0, 1, 0,      1, 1, 0, 32'h500, 32'hAABBCCDD, 4'h3, 0, 0);
    add(32'h500, 32'h0, 4'hF, 1, 0, 0, 0,      1, 1, 0, 32'h500, 32'hAABBCCDD, 4'h3, 0, 0);
    add(32'h500, 32'h0, 4'hF, 1, 0, 0, 32'h55, 0, 0, 1, 32'h500, 0, 4'hF, 32'h55, 1);
    add(32'h0,   32'h0, 4'h0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0, 1);

    // Reset state, with a write request held against it.
    #12;
    chk("rst_cpu_busy", 32'(cpu_if.busy), 32'h1);
    chk("rst_mem_wen",  32'(mem_if.wen), 32'h0);
    chk("rst_mem_ren",  32'(mem_if.ren), 32'h0);
    chk("rst_mem_addr", mem_if.addr, 32'h0);
    chk("rst_mem_wdata", mem_if.wdata, 32'h0);
    chk("rst_mem_be",   32'(mem_if.byte_en), 32'h0);
    chk("rst_cpu_rdata", cpu_if.rdata, 32'h0);
    chk("rst_wb_empty", 32'(wb_empty), 32'h1);
    $display("txn reset checked");
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 nrst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.addr, v.wdata, v.be, v.ren, v.wen, v.mbusy, v.mrdata);
      @(negedge clk);
      if (v.ren || v.wen) chk($sformatf("v%0d_cpu_busy", i), 32'(cpu_if.busy), 32'(v.e_busy));
      chk($sformatf("v%0d_mem_wen", i), 32'(mem_if.wen), 32'(v.e_wen));
      chk($sformatf("v%0d_mem_ren", i), 32'(mem_if.ren), 32'(v.e_ren));
      chk($sformatf("v%0d_wb_empty", i), 32'(wb_empty), 32'(v.e_empty));
      if (v.e_wen || v.e_ren) begin
        chk($sformatf("v%0d_mem_addr", i), mem_if.addr, v.e_addr);
        chk($sformatf("v%0d_mem_be", i), 32'(mem_if.byte_en), 32'(v.e_be));
      end
      if (v.e_wen) chk($sformatf("v%0d_mem_wdata", i), mem_if.wdata, v.e_wdata);
      if (v.ren && !v.e_busy) chk($sformatf("v%0d_cpu_rdata", i), cpu_if.rdata, v.e_rdata);
      $display("txn %0d addr=%08h ren=%0b wen=%0b mbusy=%0b -> busy=%0b mwen=%0b mren=%0b maddr=%08h rdata=%08h empty=%0b",
               i, v.addr, v.ren, v.wen, v.mbusy, cpu_if.busy, mem_if.wen, mem_if.ren,
               mem_if.addr, cpu_if.rdata, wb_empty);
      @(posedge clk); #1;
    end

    // Scenario 5: asynchronous reset while three writes are pending.
    for (int k = 0; k < 3; k++) begin
      drive(32'h700 + 32'(4 * k), 32'hA1 + 32'(k), 4'hF, 1'b0, 1'b1, 1'b1, 32'h0);
      @(posedge clk); #1;
    end
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("pre_rst_mem_wen", 32'(mem_if.wen), 32'h1);
    chk("pre_rst_wb_empty", 32'(wb_empty), 32'h0);
    #1 nrst = 1'b0;
    #1;
    chk("mid_rst_mem_wen", 32'(mem_if.wen), 32'h0);
    chk("mid_rst_wb_empty", 32'(wb_empty), 32'h1);
    $display("txn async reset mid-drain mem_wen=%0b wb_empty=%0b", mem_if.wen, wb_empty);
    @(posedge clk); #1 nrst = 1'b1;
    mem_if.busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_mem_wen", k), 32'(mem_if.wen), 32'h0);
      chk($sformatf("post_rst%0d_wb_empty", k), 32'(wb_empty), 32'h1);
      $display("txn post-reset cycle %0d mem_wen=%0b wb_empty=%0b", k, mem_if.wen, wb_empty);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
